mcu_playlist: RTL

- Parametrised successor to the player control FSM.
- Sequences an N-song playlist from one-cycle button pulses (play/pause, next, prev) and the decoder's song_done strobe.
- Drives play, the song index, and a multi-cycle reset_play pulse to the MP3 decoder/player.
- Adds prev, four playback modes (stop-at-end, repeat-all, repeat-one, shuffle) and a configurable reset pulse length.

---
 rtl/mcu_playlist.sv | 115 +++++++++++
 1 files changed

// File: rtl/mcu_playlist.sv
// Playlist sequencer: pulses in, play/song/reset_play out; one edge per event, song switches hold reset_play for RESET_CYCLES.
// No backpressure: events arriving while busy (SWITCH) are dropped, never queued.
module mcu_playlist #(
  parameter int         NUM_SONGS    = 4,
  parameter int         SONG_W       = 2,
  parameter int         RESET_CYCLES = 1,
  parameter logic [7:0] LFSR_SEED    = 8'hA5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              play_button,
  input  logic              next,
  input  logic              prev,
  input  logic [1:0]        mode,
  input  logic              song_done,
  output logic              play,
  output logic [SONG_W-1:0] song,
  output logic              reset_play,
  output logic              busy
);

  typedef enum logic [1:0] {PAUSED, PLAYING, SWITCH} state_t;

  localparam logic [SONG_W-1:0] LAST_SONG = SONG_W'(NUM_SONGS - 1);
  localparam logic [3:0]        CNT_LAST  = 4'(RESET_CYCLES - 1);

  state_t            state;
  state_t            resume;
  logic [3:0]        cnt;
  logic [7:0]        lfsr;
  logic              lfsr_fb;
  logic [SONG_W-1:0] song_inc;
  logic [SONG_W-1:0] song_dec;
  logic [SONG_W-1:0] cand;
  logic [SONG_W-1:0] shuffle_pick;
  logic              sw_go;
  logic [SONG_W-1:0] sw_song;
  state_t            sw_resume;

  assign lfsr_fb  = lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3];
  assign song_inc = (song == LAST_SONG) ? '0 : song + SONG_W'(1);
  assign song_dec = (song == '0) ? LAST_SONG : song - SONG_W'(1);
  assign cand     = lfsr[SONG_W-1:0];

  // Out-of-range or same-song candidates fall back to the wrapped successor.
  assign shuffle_pick = (({1'b0, cand} >= (SONG_W+1)'(NUM_SONGS)) || (cand == song))
                        ? song_inc : cand;

  always_comb begin
    sw_go     = 1'b0;
    sw_song   = song;
    sw_resume = state;
    if (next) begin
      sw_go   = 1'b1;
      sw_song = (mode == 2'b11) ? shuffle_pick : song_inc;
    end else if (prev) begin
      sw_go   = 1'b1;
      sw_song = song_dec;
    end else if (song_done && state == PLAYING) begin
      sw_go = 1'b1;
      case (mode)
        2'b00: begin
          sw_song = song_inc;
          if (song == LAST_SONG) sw_resume = PAUSED;
        end
        2'b01:   sw_song = song_inc;
        2'b10:   sw_song = song;
        default: sw_song = shuffle_pick;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= SWITCH;
      resume     <= PAUSED;
      cnt        <= 4'd0;
      lfsr       <= LFSR_SEED;
      song       <= '0;
      play       <= 1'b0;
      reset_play <= 1'b1;
      busy       <= 1'b1;
    end else begin
      lfsr <= {lfsr[6:0], lfsr_fb};
      case (state)
        SWITCH: begin
          if (cnt == CNT_LAST) begin
            state      <= resume;
            cnt        <= 4'd0;
            reset_play <= 1'b0;
            busy       <= 1'b0;
            play       <= (resume == PLAYING);
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        default: begin
          if (sw_go) begin
            state      <= SWITCH;
            song       <= sw_song;
            resume     <= sw_resume;
            cnt        <= 4'd0;
            reset_play <= 1'b1;
            busy       <= 1'b1;
            play       <= 1'b0;
          end else if (play_button) begin
            state <= (state == PLAYING) ? PAUSED : PLAYING;
            play  <= (state != PLAYING);
          end
        end
      endcase
    end
  end

endmodule
